maj_chain_sequencer: RTL and testbench
======================================

# maj_chain_sequencer

Time-multiplexed evaluator for majority-inverter graph (MIG) netlists. It captures one primary-input vector, then steps a single shared MAJ3 unit through a node table, one node per cycle, and returns the primary-output bit over a valid/ready handshake. It sits between a vector source and a result sink, and replaces a fully spatial MAJ network when area matters more than throughput. The node table resets to the default 10-node chain network and can be rewritten while idle.

## Interface
Parameters:
- NUM_PI, 18, number of primary inputs.
- NUM_NODES, 10, number of MAJ nodes; the last node drives the output.
- IDX_W, 5, operand index width; must satisfy 2^IDX_W ≥ NUM_PI+NUM_NODES.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector offered.
- in_ready  out  1  high only in IDLE.
- in_data  in  NUM_PI  primary inputs; pi0 is bit 0.
- out_valid  out  1  result held.
- out_ready  in  1  sink accepts the result.
- out_data  out  1  value of node NUM_NODES-1.
- busy  out  1  high in EVAL or DONE.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  IDX_W  node number to write.
- cfg_data  in  3*(IDX_W+1)  three operands, operand a in the LSBs. Each operand is {compl, idx[IDX_W-1:0]}.

## Operation
- Signal space: indices 0..NUM_PI-1 are the captured PIs. Index NUM_PI+k is the output of node k. Indices at or beyond NUM_PI+NUM_NODES read 0.
- Operand value = signal[idx] XOR compl. Node value = maj(a,b,c).
- Default table: nodes 0–5 are maj(pi3k, pi3k+1, pi3k+2) for k=0..5.
  - Node 6 = maj(n0,n1,n2).
  - Node 7 = maj(n6,n2,n3).
  - Node 8 = maj(n7,n3,n4).
  - Node 9 = maj(n8,n4,n5).
  - All complement bits are 0.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data, clear all node values to 0, set cnt=0, go to EVAL.
- State EVAL:
  - Each cycle, evaluate node cnt and write its value. cnt then increments.
  - After node NUM_NODES-1 is written, go to DONE.
  - An operand that references a node not yet evaluated reads 0. Such a reference is never stale.
- State DONE:
  - out_valid=1 and out_data holds node NUM_NODES-1.
  - On out_ready, go to IDLE.
  - in_valid is ignored in this state.
- Config writes:
  - Accepted only in IDLE with cfg_addr < NUM_NODES.
  - Writes in any other state, or with an out-of-range address, are silently dropped.
  - cfg_we in the same cycle as an input accept: the write lands, and the accepted vector uses the new table.
- in_data may change freely after the accept cycle.
- out_data is undefined-but-stable outside DONE; the implementation drives 0.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, cnt=0, table = default, node values 0.
- Latency: accept at edge E0; node k is written at edge E(k+1); out_valid rises after edge E(NUM_NODES). This is 10 cycles for the default table.
- Throughput: one vector per NUM_NODES+2 cycles when out_ready is tied high. There is no overlap between vectors.
- Backpressure: out_valid and out_data hold indefinitely until out_ready is high.
- rst mid-EVAL or mid-DONE: the next cycle is IDLE with out_valid=0, and the in-flight vector is discarded. The table also resets to default.
- busy equals (state != IDLE), registered.

## Structure
- Package maj_pkg holds:
  - the NUM_PI, NUM_NODES and IDX_W constants;
  - the operand_t struct {compl, idx};
  - the node_t struct {a, b, c};
  - the state enum {IDLE, EVAL, DONE};
  - the DEFAULT_TABLE constant array.
- Sub-module maj3_unit: purely combinational. Three operand values plus three complement bits in, one bit out. Instantiated once.
- The table and value files are flop arrays; no RAM macro.

## Test plan
- in_data=18'h3FFFF, out_ready=1 → out_valid rises exactly 10 cycles after the accept edge with out_data=1. Then IDLE.
- in_data=18'h00000 → out_data=0. Also check in_data=18'h001FF → 0 and 18'h3FFC0 → 1.
- in_data=18'h3FFC0 with out_ready held low for 20 cycles → out_valid and out_data=1 stay stable. in_ready=0 and a second in_valid is ignored. Releasing out_ready gives IDLE one cycle later.
- Assert rst during EVAL cycle 5 → next cycle out_valid=0, in_ready=1, busy=0. A new vector 18'h3FFFF then yields 1.
- While IDLE, write cfg_addr=9, cfg_data={op c=idx1/compl0, op b=idx0/compl0, op a=idx0/compl0}. Then in_data=18'h00001 → out_data=1 and 18'h00002 → 0. The same write issued during EVAL is dropped and the default result is unchanged.
- Write cfg_addr=6 with operand a = idx 27 (a forward reference) → that operand reads 0. The result matches a reference model that uses this rule.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared constants, table record types, FSM state encoding and the reset-time
// node table for the MIG chain sequencer.
package maj_pkg;

  localparam int NUM_PI    = 18;
  localparam int NUM_NODES = 10;
  localparam int IDX_W     = 5;

  typedef struct packed {
    logic             compl;
    logic [IDX_W-1:0] idx;
  } operand_t;

  // Operand a occupies the LSBs so a raw cfg_data word casts straight to a node.
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } node_t;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  function automatic node_t mk_node(input int a, input int b, input int c);
    node_t n;
    n.a = '{compl: 1'b0, idx: IDX_W'(a)};
    n.b = '{compl: 1'b0, idx: IDX_W'(b)};
    n.c = '{compl: 1'b0, idx: IDX_W'(c)};
    return n;
  endfunction

  // Six PI triplets feed a ripple of majorities that ends in node 9.
  localparam node_t DEFAULT_TABLE [NUM_NODES] = '{
    mk_node(0, 1, 2),
    mk_node(3, 4, 5),
    mk_node(6, 7, 8),
    mk_node(9, 10, 11),
    mk_node(12, 13, 14),
    mk_node(15, 16, 17),
    mk_node(NUM_PI + 0, NUM_PI + 1, NUM_PI + 2),
    mk_node(NUM_PI + 6, NUM_PI + 2, NUM_PI + 3),
    mk_node(NUM_PI + 7, NUM_PI + 3, NUM_PI + 4),
    mk_node(NUM_PI + 8, NUM_PI + 4, NUM_PI + 5)
  };

endpackage

// File: rtl/maj3_unit.sv
// Single shared majority gate: applies per-operand complement, then votes.
module maj3_unit (
  input  logic [2:0] op_val,
  input  logic [2:0] op_compl,
  output logic       maj
);

  logic [2:0] v;

  assign v   = op_val ^ op_compl;
  assign maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);

endmodule

// File: rtl/maj_chain_sequencer.sv
// Time-multiplexed MIG evaluator: captures a PI vector, walks the node table
// one node per cycle through one MAJ3 unit, and hands back the last node.
module maj_chain_sequencer #(
  parameter int NUM_PI    = maj_pkg::NUM_PI,
  parameter int NUM_NODES = maj_pkg::NUM_NODES,
  parameter int IDX_W     = maj_pkg::IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PI-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_data,
  output logic                   busy,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_addr,
  input  logic [3*(IDX_W+1)-1:0] cfg_data
);

  import maj_pkg::*;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NODES - 1);

  state_t               state, state_nxt;
  logic [NUM_PI-1:0]    pi_q;
  logic [NUM_NODES-1:0] val_q;
  node_t                table_q [NUM_NODES];
  logic [IDX_W-1:0]     cnt;

  logic       accept, cfg_ok, last_node, node_val;
  node_t      cur_node;
  logic [2:0] op_val, op_compl;

  // Out-of-range indices fall through to 0; cleared node values make
  // forward references read 0 as well.
  function automatic logic sig_at(input logic [IDX_W-1:0] idx,
                                  input logic [NUM_PI-1:0] pis,
                                  input logic [NUM_NODES-1:0] vals);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NUM_PI; k++)
      if (idx == IDX_W'(k)) r = pis[k];
    for (int k = 0; k < NUM_NODES; k++)
      if (idx == IDX_W'(NUM_PI + k)) r = vals[k];
    return r;
  endfunction

  assign accept    = (state == IDLE) && in_valid;
  assign cfg_ok    = (state == IDLE) && cfg_we && (cfg_addr <= LAST);
  assign last_node = (cnt == LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cur_node = '0;
    for (int k = 0; k < NUM_NODES; k++)
      if (cnt == IDX_W'(k)) cur_node = table_q[k];
  end

  assign op_val   = {sig_at(cur_node.c.idx, pi_q, val_q),
                     sig_at(cur_node.b.idx, pi_q, val_q),
                     sig_at(cur_node.a.idx, pi_q, val_q)};
  assign op_compl = {cur_node.c.compl, cur_node.b.compl, cur_node.a.compl};

  maj3_unit u_maj3 (
    .op_val  (op_val),
    .op_compl(op_compl),
    .maj     (node_val)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = EVAL;
      EVAL:    if (last_node) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = (state == DONE) ? val_q[NUM_NODES-1] : 1'b0;
  end

  // Datapath: table writes, PI capture, node value file, node counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q  <= '0;
      val_q <= '0;
      cnt   <= '0;
      // NOTE: the table is a flop array with a defined power-up network, so it is reset explicitly.
      for (int k = 0; k < NUM_NODES; k++) table_q[k] <= DEFAULT_TABLE[k];
    end else begin
      if (cfg_ok)
        for (int k = 0; k < NUM_NODES; k++)
          if (cfg_addr == IDX_W'(k)) table_q[k] <= node_t'(cfg_data);
      if (accept) begin
        pi_q  <= in_data;
        val_q <= '0;
        cnt   <= '0;
      end else if (state == EVAL) begin
        for (int k = 0; k < NUM_NODES; k++)
          if (cnt == IDX_W'(k)) val_q[k] <= node_val;
        cnt <= last_node ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maj_chain_sequencer.sv
// Self-checking bench for maj_chain_sequencer: vector table, directed corner
// sequences, and randomized vectors/tables against a signal-array model.
module tb_maj_chain_sequencer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_data, busy, cfg_we;
  logic [17:0] in_data, cfg_data;
  logic [4:0]  cfg_addr;

  int checks   = 0;
  int failures = 0;

  int m_idx [10][3];
  bit m_cpl [10][3];

  typedef struct packed {
    logic [17:0] pis;
    logic        exp;
  } vec_t;

  vec_t vecs [4];

  maj_chain_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: signal space as a flat array, nodes evaluated in order.
  function automatic bit ref_out(input logic [17:0] pis);
    bit sig [32];
    int ones;
    for (int i = 0; i < 32; i++) sig[i] = 1'b0;
    for (int i = 0; i < 18; i++) sig[i] = pis[i];
    for (int k = 0; k < 10; k++) begin
      ones = 0;
      for (int j = 0; j < 3; j++) ones += int'(sig[m_idx[k][j]] ^ m_cpl[k][j]);
      sig[18 + k] = (ones >= 2);
    end
    return sig[27];
  endfunction

  task automatic model_set(input int n, input int ia, input bit ca, input int ib,
                           input bit cb, input int ic, input bit cc);
    m_idx[n][0] = ia; m_cpl[n][0] = ca;
    m_idx[n][1] = ib; m_cpl[n][1] = cb;
    m_idx[n][2] = ic; m_cpl[n][2] = cc;
  endtask

  task automatic model_default();
    for (int k = 0; k < 6; k++) model_set(k, 3*k, 0, 3*k + 1, 0, 3*k + 2, 0);
    model_set(6, 18, 0, 19, 0, 20, 0);
    model_set(7, 24, 0, 20, 0, 21, 0);
    model_set(8, 25, 0, 21, 0, 22, 0);
    model_set(9, 26, 0, 22, 0, 23, 0);
  endtask

  function automatic logic [17:0] enc(input int ia, input bit ca, input int ib,
                                      input bit cb, input int ic, input bit cc);
    return {cc, 5'(ic), cb, 5'(ib), ca, 5'(ia)};
  endfunction

  task automatic cfg_idle(input int addr, input int ia, input bit ca, input int ib,
                          input bit cb, input int ic, input bit cc);
    cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_data = enc(ia, ca, ib, cb, ic, cc);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < 10) model_set(addr, ia, ca, ib, cb, ic, cc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_default();
  endtask

  // Called right after the accept edge (+1); waits for the result, then lets
  // it drain (out_ready assumed high) and checks the return to IDLE.
  task automatic wait_result(input string name, input bit exp);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, lat, 10);
    check({name, " data"}, out_data, exp);
    @(posedge clk); #1;
    check({name, " idle"}, {in_ready, busy, out_valid}, 3'b100);
  endtask

  task automatic run_vec(input string name, input logic [17:0] pis, input bit exp);
    check({name, " ready"}, in_ready, 1);
    in_valid = 1'b1; in_data = pis;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 18'($urandom);
    wait_result(name, exp);
  endtask

  initial begin
    logic [17:0] p;
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_default();
    check("reset outputs", {in_ready, out_valid, out_data, busy}, 4'b1000);

    vecs[0] = '{pis: 18'h3FFFF, exp: 1'b1};
    vecs[1] = '{pis: 18'h00000, exp: 1'b0};
    vecs[2] = '{pis: 18'h001FF, exp: 1'b0};
    vecs[3] = '{pis: 18'h3FFC0, exp: 1'b1};
    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i].pis, vecs[i].exp);

    // Backpressure: result held, second vector ignored, release -> IDLE.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 18'h3FFC0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp latency", lat, 10);
    in_valid = 1'b1; in_data = 18'h00000;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp hold", {out_valid, out_data, in_ready, busy}, 4'b1101);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp release", {out_valid, in_ready, busy}, 3'b010);

    // Reset during EVAL cycle 5.
    in_valid = 1'b1; in_data = 18'h00000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("mid-eval busy", busy, 1);
    do_reset();
    check("rst mid-eval", {out_valid, in_ready, busy}, 3'b010);
    run_vec("after rst", 18'h3FFFF, 1'b1);

    // Node 9 rewritten to maj(pi0, pi0, pi1).
    cfg_idle(9, 0, 0, 0, 0, 1, 0);
    run_vec("cfg9 p1", 18'h00001, 1'b1);
    run_vec("cfg9 p2", 18'h00002, 1'b0);

    // Same write during EVAL is dropped.
    do_reset();
    in_valid = 1'b1; in_data = 18'h00001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 5'd9; cfg_data = enc(0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("eval-write data", out_data, 0);
    @(posedge clk); #1;
    run_vec("eval-write kept", 18'h00001, 1'b0);

    // Out-of-range address in IDLE is dropped.
    cfg_idle(12, 0, 1, 0, 1, 0, 1);
    run_vec("oob addr", 18'h3FFC0, 1'b1);

    // Write in the accept cycle lands and is used by that vector.
    cfg_we = 1'b1; cfg_addr = 5'd9; cfg_data = enc(0, 0, 0, 0, 1, 0);
    in_valid = 1'b1; in_data = 18'h00001;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    model_set(9, 0, 0, 0, 0, 1, 0);
    wait_result("accept+cfg", 1'b1);

    // Forward reference from node 6 to node 9.
    do_reset();
    cfg_idle(6, 27, 0, 19, 0, 20, 0);
    for (int i = 0; i < 8; i++) begin
      p = 18'($urandom);
      run_vec($sformatf("fwd%0d", i), p, ref_out(p));
    end

    // Random vectors on the default table.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p = 18'($urandom);
      run_vec($sformatf("rnd%0d", i), p, ref_out(p));
    end

    // Random table rewrites, including out-of-range addresses.
    for (int i = 0; i < 30; i++) begin
      cfg_idle($urandom_range(0, 15),
               $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 31), 1'($urandom),
               $urandom_range(0, 31), 1'($urandom));
      p = 18'($urandom);
      run_vec($sformatf("rtab%0d", i), p, ref_out(p));
    end

    // Reset restores the default table.
    do_reset();
    run_vec("table restored", 18'h001FF, 1'b0);
    run_vec("table restored2", 18'h3FFC0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
